// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and encodings for the multicycle RISC-V control unit.
// The TRAP state exists only when MULTICYCLE_CTRL_TRAP_EN is defined.
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMREAD,
        MEMWB,
        MEMWRITE,
        EXEC_R,
        EXEC_I,
        ALUWB,
        BEQ,
        JAL
`ifdef MULTICYCLE_CTRL_TRAP_EN
        ,
        TRAP
`endif
    } state_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic       ADR_PC     = 1'b0;
    localparam logic       ADR_RESULT = 1'b1;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// Combinational ALU operation decode for the EXEC_R / EXEC_I states.
module alu_decoder
    import multicycle_ctrl_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       rtype,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (funct3)
            3'b000:  alu_control = (rtype && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_control = ALU_SLT;
            3'b110:  alu_control = ALU_OR;
            3'b111:  alu_control = ALU_AND;
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for a multicycle RISC-V datapath with optional memory-wait timeout.
// Define MULTICYCLE_CTRL_TRAP_EN to trap on unknown opcodes instead of treating them as NOPs.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int WAIT_TIMEOUT = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] imm_src,
    output logic [2:0] alu_control,
    output logic       mem_timeout
`ifdef MULTICYCLE_CTRL_TRAP_EN
    ,
    output logic       trap
`endif
);

    state_t     state, state_n;
    logic       expired;
    logic       ready_eff;
    logic [2:0] alu_dec;

    always_ff @(posedge clk) begin
        if (!rst) state <= FETCH;
        else      state <= state_n;
    end

    // The wait counter restarts whenever the FSM changes state, which covers every entry into a wait state.
    generate
        if (WAIT_TIMEOUT > 0) begin : g_timeout
            localparam int CNT_W = $clog2(WAIT_TIMEOUT + 1);
            logic [CNT_W-1:0] cnt;
            logic             wait_st;

            assign wait_st = (state == FETCH) || (state == MEMREAD) || (state == MEMWRITE);
            assign expired = wait_st && !mem_ready && (cnt == CNT_W'(WAIT_TIMEOUT - 1));

            always_ff @(posedge clk) begin
                if (!rst)                      cnt <= '0;
                else if (state_n != state)     cnt <= '0;
                else if (wait_st && !mem_ready) cnt <= cnt + 1'b1;
            end
        end else begin : g_no_timeout
            assign expired = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst)        mem_timeout <= 1'b0;
        else if (expired) mem_timeout <= 1'b1;
    end

    assign ready_eff = mem_ready | expired;

    alu_decoder u_alu_decoder (
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .rtype       (state == EXEC_R),
        .alu_control (alu_dec)
    );

    always_comb begin
        state_n     = state;
        pc_write    = 1'b0;
        ir_write    = 1'b0;
        mem_write   = 1'b0;
        reg_write   = 1'b0;
        adr_src     = ADR_PC;
        result_src  = RES_ALUOUT;
        alu_src_a   = SRCA_PC;
        alu_src_b   = SRCB_RD2;
        alu_control = ALU_ADD;
`ifdef MULTICYCLE_CTRL_TRAP_EN
        trap        = 1'b0;
`endif
        case (state)
            FETCH: begin
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
                if (ready_eff) state_n = DECODE;
            end
            DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                case (op)
                    OP_LW, OP_SW: state_n = MEMADR;
                    OP_RTYPE:     state_n = EXEC_R;
                    OP_ITYPE:     state_n = EXEC_I;
                    OP_BEQ:       state_n = BEQ;
                    OP_JAL:       state_n = JAL;
`ifdef MULTICYCLE_CTRL_TRAP_EN
                    default:      state_n = TRAP;
`else
                    default:      state_n = FETCH;
`endif
                endcase
            end
            MEMADR: begin
                alu_src_a = SRCA_RD1;
                alu_src_b = SRCB_IMM;
                state_n   = (op == OP_LW) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                adr_src = ADR_RESULT;
                if (ready_eff) state_n = MEMWB;
            end
            MEMWB: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
                state_n    = FETCH;
            end
            MEMWRITE: begin
                adr_src   = ADR_RESULT;
                mem_write = 1'b1;
                if (ready_eff) state_n = FETCH;
            end
            EXEC_R: begin
                alu_src_a   = SRCA_RD1;
                alu_src_b   = SRCB_RD2;
                alu_control = alu_dec;
                state_n     = ALUWB;
            end
            EXEC_I: begin
                alu_src_a   = SRCA_RD1;
                alu_src_b   = SRCB_IMM;
                alu_control = alu_dec;
                state_n     = ALUWB;
            end
            ALUWB: begin
                reg_write = 1'b1;
                state_n   = FETCH;
            end
            BEQ: begin
                alu_src_a   = SRCA_RD1;
                alu_src_b   = SRCB_RD2;
                alu_control = ALU_SUB;
                pc_write    = zero;
                state_n     = FETCH;
            end
            JAL: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                pc_write  = 1'b1;
                state_n   = ALUWB;
            end
`ifdef MULTICYCLE_CTRL_TRAP_EN
            TRAP: begin
                trap = 1'b1;
            end
`endif
            default: state_n = FETCH;
        endcase
        // Reset aborts whatever the current state would have written.
        if (!rst) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
        end
    end

    always_comb begin
        imm_src = IMM_I;
        case (op)
            OP_SW:   imm_src = IMM_S;
            OP_BEQ:  imm_src = IMM_B;
            OP_JAL:  imm_src = IMM_J;
            default: imm_src = IMM_I;
        endcase
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have parameter WAIT_TIMEOUT, default 0, meaning the maximum number of cycles to wait for mem_ready (0 = unlimited).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port op, input, 7 bits: instruction opcode from the instruction register.
REQ-005 The block SHALL have port funct3, input, 3 bits: instruction funct3.
REQ-006 The block SHALL have port funct7b5, input, 1 bit: instruction bit 30.
REQ-007 The block SHALL have port zero, input, 1 bit: ALU Zero flag.
REQ-008 The block SHALL have port mem_ready, input, 1 bit: the memory completed the current access this cycle.
REQ-009 The block SHALL have outputs pc_write, adr_src, mem_write, ir_write and reg_write, each 1 bit: datapath enables and selects.
REQ-010 The block SHALL have outputs result_src, alu_src_a, alu_src_b and imm_src, each 2 bits: mux selects.
REQ-011 The block SHALL have output alu_control, 3 bits, encoded 000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-012 The block SHALL have output mem_timeout, 1 bit: sticky flag set when a memory wait expires.

Function
REQ-013 The block SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXEC_R, EXEC_I, ALUWB, BEQ and JAL; ir_write, pc_write and mem_write are additionally gated by mem_ready or zero as stated below.
REQ-014 FETCH SHALL drive adr_src=0, alu_src_a=00, alu_src_b=10, add and result_src=10; ir_write and pc_write SHALL equal mem_ready; FETCH SHALL hold until mem_ready, then go to DECODE.
REQ-015 DECODE SHALL drive alu_src_a=01, alu_src_b=01 and add, then branch on op: 0000011 or 0100011 to MEMADR, 0110011 to EXEC_R, 0010011 to EXEC_I, 1100011 to BEQ, 1101111 to JAL, and any other opcode to FETCH (executed as a NOP).
REQ-016 MEMADR SHALL drive alu_src_a=10, alu_src_b=01 and add, then go to MEMREAD when op=0000011, otherwise to MEMWRITE.
REQ-017 MEMREAD SHALL drive adr_src=1 and result_src=00, holding until mem_ready, then go to MEMWB.
REQ-018 MEMWB SHALL drive result_src=01 and reg_write=1, then go to FETCH.
REQ-019 MEMWRITE SHALL drive adr_src=1 and result_src=00, with mem_write=1 held each cycle until mem_ready, then go to FETCH.
REQ-020 EXEC_R SHALL drive alu_src_a=10 and alu_src_b=00; EXEC_I SHALL drive alu_src_a=10 and alu_src_b=01; both SHALL then go to ALUWB.
REQ-021 In EXEC_R and EXEC_I the ALU decode SHALL map funct3 as follows: 000 gives sub only when EXEC_R and funct7b5=1, otherwise add; 010 gives slt; 110 gives or; 111 gives and; any other funct3 gives add.
REQ-022 ALUWB SHALL drive result_src=00 and reg_write=1, then go to FETCH.
REQ-023 BEQ SHALL drive alu_src_a=10, alu_src_b=00, sub, result_src=00 and pc_write=zero, then go to FETCH.
REQ-024 JAL SHALL drive alu_src_a=01, alu_src_b=10, add, result_src=00 and pc_write=1, then go to ALUWB.
REQ-025 imm_src SHALL be decoded combinationally from op: 00 for I-type and lw, 01 for sw, 10 for beq, 11 for jal, and 00 otherwise.
REQ-026 In any state not listed for a given output, that output SHALL be 0 and its selects SHALL be 00.
REQ-027 When WAIT_TIMEOUT>0, a wait counter SHALL clear on entry to FETCH, MEMREAD or MEMWRITE and increment each cycle while mem_ready=0.
REQ-028 When that counter reaches WAIT_TIMEOUT, the block SHALL set mem_timeout and leave the state as if mem_ready=1.
REQ-029 mem_timeout SHALL stay set until reset.
REQ-030 mem_ready=1 on the same cycle the timeout is reached SHALL NOT set mem_timeout.

Reset
REQ-031 With rst=0 at a clk edge, the FSM SHALL enter FETCH, the wait counter SHALL clear and mem_timeout SHALL clear.
REQ-032 During reset, all enables (pc_write, ir_write, mem_write, reg_write) SHALL be forced to 0.
REQ-033 Reset asserted in any state, including mid-wait, SHALL abort that state with no write strobe in the reset cycle.

Configuration
REQ-034 When MULTICYCLE_CTRL_TRAP_EN is defined, the block SHALL add a state TRAP and an output trap (1 bit).
REQ-035 With MULTICYCLE_CTRL_TRAP_EN defined, an unknown opcode in DECODE SHALL go to TRAP; TRAP SHALL hold all enables at 0 and trap=1 until reset.
REQ-036 Without MULTICYCLE_CTRL_TRAP_EN, an unknown opcode SHALL be treated as a NOP and no trap port SHALL exist.

Structure
REQ-037 A shared package SHALL hold the state enum, the opcode constants, the alu_control encodings and the mux-select constants.
REQ-038 The ALU decode SHALL be a combinational sub-module named alu_decoder.

Verification
REQ-039 Reset then lw (op=0000011) with mem_ready=1 SHALL visit FETCH, DECODE, MEMADR, MEMREAD, MEMWB, FETCH, with reg_write=1 only in MEMWB.
REQ-040 sw with mem_ready low for 3 cycles in MEMWRITE SHALL hold mem_write=1 for 4 cycles, then return to FETCH.
REQ-041 R-type with funct3=000 and funct7b5=1 SHALL give alu_control=001 in EXEC_R; I-type with the same funct3 and funct7b5 SHALL give 000.
REQ-042 beq with zero=1 SHALL give pc_write=1 in BEQ; with zero=0 it SHALL give pc_write=0.
REQ-043 With WAIT_TIMEOUT=4 and mem_ready stuck at 0 in FETCH, mem_timeout SHALL rise after 4 cycles, the FSM SHALL move to DECODE, and mem_timeout SHALL clear only on reset.
REQ-044 With MULTICYCLE_CTRL_TRAP_EN defined, op=1111111 SHALL put the FSM in TRAP with trap=1; rst=0 for one cycle SHALL return it to FETCH.
